// File: rtl/text_console_writer.sv
// ASCII byte stream to 40x30 screen character buffer writer.
// Tracks the cursor and handles wrap, newline, backspace, form-feed and clears.
module text_console_writer #(
  parameter int unsigned COLS  = 40,
  parameter int unsigned ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h00
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  input  logic        clear,
  output logic [10:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_wr,
  input  logic        mem_busy,
  output logic [5:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        idle
);

  localparam logic [10:0] LastIdx = 11'(COLS * ROWS - 1);
  localparam logic [5:0]  LastCol = 6'(COLS - 1);
  localparam logic [4:0]  LastRow = 5'(ROWS - 1);
  localparam logic [10:0] ColsW   = 11'(COLS);

  typedef enum logic [2:0] {StClrAll, StIdle, StPut, StBksp, StClrRow} state_e;
  typedef enum logic [1:0] {PhIssue, PhWr, PhGuard, PhWait} phase_e;

  state_e      state_q;
  phase_e      phase_q;
  logic [5:0]  col_q;
  logic [4:0]  row_q;
  logic [10:0] base_q;
  logic [10:0] addr_q;
  logic [7:0]  din_q;
  logic        wr_q;
  logic        clear_pending_q;
  logic [5:0]  cnt_q;

  logic        nl_wrap;
  logic [4:0]  nl_row;
  logic [10:0] nl_base;
  logic [10:0] cur_addr;

  // Next row and its base for a newline; the screen wraps instead of scrolling.
  always_comb begin
    nl_wrap  = (row_q == LastRow);
    nl_row   = nl_wrap ? 5'd0 : row_q + 5'd1;
    nl_base  = nl_wrap ? 11'd0 : base_q + ColsW;
    cur_addr = base_q + {5'd0, col_q};
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q         <= StClrAll;
      phase_q         <= PhIssue;
      col_q           <= '0;
      row_q           <= '0;
      base_q          <= '0;
      addr_q          <= '0;
      din_q           <= BLANK;
      wr_q            <= 1'b0;
      clear_pending_q <= 1'b0;
      cnt_q           <= '0;
    end else begin
      if (clear) clear_pending_q <= 1'b1;
      if (state_q == StIdle) begin
        if (clear_pending_q || clear) begin
          clear_pending_q <= 1'b0;
          state_q         <= StClrAll;
          phase_q         <= PhWr;
          wr_q            <= 1'b1;
          addr_q          <= '0;
          din_q           <= BLANK;
        end else if (ch_valid) begin
          if (ch_data >= 8'h20 && ch_data <= 8'h7F) begin
            state_q <= StPut;
            phase_q <= PhWr;
            wr_q    <= 1'b1;
            addr_q  <= cur_addr;
            din_q   <= ch_data - 8'h20;
          end else if (ch_data == 8'h0A) begin
            col_q   <= '0;
            row_q   <= nl_row;
            base_q  <= nl_base;
            addr_q  <= nl_base;
            din_q   <= BLANK;
            cnt_q   <= '0;
            state_q <= StClrRow;
            phase_q <= PhWr;
            wr_q    <= 1'b1;
          end else if (ch_data == 8'h0D) begin
            col_q <= '0;
          end else if (ch_data == 8'h08) begin
            if (col_q != 6'd0) begin
              addr_q  <= cur_addr - 11'd1;
              din_q   <= BLANK;
              state_q <= StBksp;
              phase_q <= PhWr;
              wr_q    <= 1'b1;
            end
          end else if (ch_data == 8'h0C) begin
            state_q <= StClrAll;
            phase_q <= PhWr;
            wr_q    <= 1'b1;
            addr_q  <= '0;
            din_q   <= BLANK;
          end
        end
      end else begin
        unique case (phase_q)
          PhIssue: begin
            wr_q    <= 1'b1;
            phase_q <= PhWr;
          end
          PhWr: begin
            wr_q    <= 1'b0;
            phase_q <= PhGuard;
          end
          PhGuard: phase_q <= PhWait;
          PhWait: begin
            if (!mem_busy) begin
              case (state_q)
                StClrAll: begin
                  if (addr_q == LastIdx) begin
                    col_q   <= '0;
                    row_q   <= '0;
                    base_q  <= '0;
                    state_q <= StIdle;
                  end else begin
                    addr_q  <= addr_q + 11'd1;
                    wr_q    <= 1'b1;
                    phase_q <= PhWr;
                  end
                end
                StClrRow: begin
                  if (cnt_q == LastCol) begin
                    state_q <= StIdle;
                  end else begin
                    cnt_q   <= cnt_q + 6'd1;
                    addr_q  <= addr_q + 11'd1;
                    wr_q    <= 1'b1;
                    phase_q <= PhWr;
                  end
                end
                StPut: begin
                  if (col_q == LastCol) begin
                    col_q   <= '0;
                    row_q   <= nl_row;
                    base_q  <= nl_base;
                    addr_q  <= nl_base;
                    din_q   <= BLANK;
                    cnt_q   <= '0;
                    state_q <= StClrRow;
                    phase_q <= PhWr;
                    wr_q    <= 1'b1;
                  end else begin
                    col_q   <= col_q + 6'd1;
                    state_q <= StIdle;
                  end
                end
                StBksp: begin
                  col_q   <= col_q - 6'd1;
                  state_q <= StIdle;
                end
                default: state_q <= StIdle;
              endcase
            end
          end
        endcase
      end
    end
  end

  assign ch_ready   = (state_q == StIdle) && !clear_pending_q && !clear;
  assign idle       = ch_ready;
  assign mem_addr   = addr_q;
  assign mem_din    = din_q;
  assign mem_wr     = wr_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule
